// File: rtl/line_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : line_window_ctrl
// Purpose  : 3x3 sliding-window generator driving two cascaded line FIFOs.
//            Optional LWC_FRAME_CNT_EN adds a 16-bit completed-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module line_window_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 9
) (
    input  logic                    LWC_Clk,
    input  logic                    LWC_Reset,
    input  logic                    LWC_Pixel_valid,
    input  logic [DATA_WIDTH-1:0]   LWC_Pixel_data,
    output logic                    LWC_Pixel_ready,
    input  logic [DATA_WIDTH-1:0]   LWC_Fifo0_out,
    input  logic [DATA_WIDTH-1:0]   LWC_Fifo1_out,
    output logic                    LWC_Fifo0_Wen,
    output logic                    LWC_Fifo1_Wen,
    output logic                    LWC_Fifo0_Ren,
    output logic                    LWC_Fifo1_Ren,
    output logic                    LWC_Rdinc,
    output logic                    LWC_Rdptclr,
    output logic                    LWC_Wrptclr,
    output logic [DATA_WIDTH-1:0]   LWC_Fifo0_in,
    output logic [DATA_WIDTH-1:0]   LWC_Fifo1_in,
    output logic [9*DATA_WIDTH-1:0] LWC_Window,
    output logic                    LWC_Window_valid,
    output logic                    LWC_Frame_done
`ifdef LWC_FRAME_CNT_EN
    ,
    output logic [15:0]             LWC_Frame_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [COL_WIDTH-1:0] c_col_last = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] c_row_last = ROW_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [COL_WIDTH-1:0] c_col_two  = COL_WIDTH'(2);
    localparam logic [ROW_WIDTH-1:0] c_row_two  = ROW_WIDTH'(2);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_flush_cnt;
    logic [COL_WIDTH-1:0]    r_col;
    logic [ROW_WIDTH-1:0]    r_row;

    logic                    r_pixel_ready;
    logic                    r_rdptclr;
    logic                    r_wrptclr;
    logic                    r_frame_done;

    // Stage 1 (read issue): Rdinc doubles as the stage-1 valid flag.
    logic                    r_rdinc;
    logic                    r_fifo0_ren;
    logic                    r_fifo1_ren;
    logic [DATA_WIDTH-1:0]   r_s1_pix;
    logic                    r_s1_win_ok;

    // Stage 2 (write back / column formation): Fifo0_Wen is the stage-2 valid.
    logic                    r_fifo0_wen;
    logic                    r_fifo1_wen;
    logic [DATA_WIDTH-1:0]   r_fifo0_in;
    logic                    r_s2_row_ge2;
    logic                    r_s2_win_ok;

    logic [8:0][DATA_WIDTH-1:0] r_window;
    logic                    r_window_valid;

    logic                    w_accept;
    logic                    w_last_col;
    logic                    w_frame_end;
    logic [DATA_WIDTH-1:0]   w_top;
    logic [DATA_WIDTH-1:0]   w_mid;

    assign w_accept    = LWC_Pixel_valid & r_pixel_ready;
    assign w_last_col  = (r_col == c_col_last);
    assign w_frame_end = (r_state == ST_CLEAR) && (r_row == c_row_last);

    // ------------------------------------------------------------------
    // Row-sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_accept && w_last_col) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt)            w_state_nxt = ST_CLEAR;
            ST_CLEAR:                             w_state_nxt = ST_RUN;
            default:                              w_state_nxt = ST_RUN;
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_flush_cnt   <= 1'b0;
            r_pixel_ready <= 1'b0;
            r_rdptclr     <= 1'b0;
            r_wrptclr     <= 1'b0;
        end else begin
            r_flush_cnt   <= (r_state == ST_FLUSH) ? ~r_flush_cnt : 1'b0;
            r_pixel_ready <= (w_state_nxt == ST_RUN);
            r_rdptclr     <= (w_state_nxt != ST_CLEAR);
            r_wrptclr     <= (w_state_nxt != ST_CLEAR);
        end
    end

    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_col <= '0;
            r_row <= (r_row == c_row_last) ? '0 : r_row + ROW_WIDTH'(1);
        end else if (w_accept && !w_last_col) begin
            r_col <= r_col + COL_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_rdinc      <= 1'b0;
            r_fifo0_ren  <= 1'b0;
            r_fifo1_ren  <= 1'b0;
            r_s1_pix     <= '0;
            r_s1_win_ok  <= 1'b0;
            r_fifo0_wen  <= 1'b0;
            r_fifo1_wen  <= 1'b0;
            r_fifo0_in   <= '0;
            r_s2_row_ge2 <= 1'b0;
            r_s2_win_ok  <= 1'b0;
        end else begin
            r_rdinc      <= w_accept;
            r_fifo0_ren  <= w_accept && (r_row != '0);
            r_fifo1_ren  <= w_accept && (r_row >= c_row_two);
            r_s1_win_ok  <= w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);
            if (w_accept) begin
                r_s1_pix <= LWC_Pixel_data;
            end

            r_fifo0_wen  <= r_rdinc;
            r_fifo1_wen  <= r_fifo0_ren;
            r_s2_row_ge2 <= r_fifo1_ren;
            r_s2_win_ok  <= r_s1_win_ok;
            if (r_rdinc) begin
                r_fifo0_in <= r_s1_pix;
            end
        end
    end

    // Rows that were not read contribute zeros rather than whatever the FIFO
    // output register happens to hold.
    assign w_mid = r_fifo1_wen  ? LWC_Fifo0_out : '0;
    assign w_top = r_s2_row_ge2 ? LWC_Fifo1_out : '0;

    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_window       <= '0;
            r_window_valid <= 1'b0;
        end else begin
            r_window_valid <= r_fifo0_wen & r_s2_win_ok;
            if (r_fifo0_wen) begin
                r_window <= {r_fifo0_in, r_window[8:7],
                             w_mid,      r_window[5:4],
                             w_top,      r_window[2:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame completion
    // ------------------------------------------------------------------
`ifdef LWC_FRAME_CNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign LWC_Frame_count = r_frame_count;
`else
    always_ff @(posedge LWC_Clk) begin
        if (LWC_Reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
        end
    end
`endif

    assign LWC_Pixel_ready  = r_pixel_ready;
    assign LWC_Rdptclr      = r_rdptclr;
    assign LWC_Wrptclr      = r_wrptclr;
    assign LWC_Rdinc        = r_rdinc;
    assign LWC_Fifo0_Ren    = r_fifo0_ren;
    assign LWC_Fifo1_Ren    = r_fifo1_ren;
    assign LWC_Fifo0_Wen    = r_fifo0_wen;
    assign LWC_Fifo1_Wen    = r_fifo1_wen;
    assign LWC_Fifo0_in     = r_fifo0_in;
    // FIFO0's output register already provides the pipeline stage for the cascade.
    assign LWC_Fifo1_in     = LWC_Fifo0_out;
    assign LWC_Window       = r_window;
    assign LWC_Window_valid = r_window_valid;
    assign LWC_Frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_line_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_ctrl
// Purpose  : Scoreboard bench for line_window_ctrl with two line-FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_window_ctrl;

    localparam int DW    = 16;
    localparam int W     = 5;
    localparam int H     = 4;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pv  = 1'b0;
    logic [DW-1:0]      pd  = '0;
    logic               ready, wen0, wen1, ren0, ren1, rdinc, rdclr, wrclr;
    logic [DW-1:0]      f0_in, f1_in;
    logic [DW-1:0]      f0_out = '0;
    logic [DW-1:0]      f1_out = '0;
    logic [9*DW-1:0]    window;
    logic               win_valid, fdone;
`ifdef LWC_FRAME_CNT_EN
    logic [15:0]        fcnt;
`endif

    always #5 clk = ~clk;

    line_window_ctrl #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COL_WIDTH  (10),
        .ROW_WIDTH  (9)
    ) dut (
        .LWC_Clk          (clk),
        .LWC_Reset        (rst),
        .LWC_Pixel_valid  (pv),
        .LWC_Pixel_data   (pd),
        .LWC_Pixel_ready  (ready),
        .LWC_Fifo0_out    (f0_out),
        .LWC_Fifo1_out    (f1_out),
        .LWC_Fifo0_Wen    (wen0),
        .LWC_Fifo1_Wen    (wen1),
        .LWC_Fifo0_Ren    (ren0),
        .LWC_Fifo1_Ren    (ren1),
        .LWC_Rdinc        (rdinc),
        .LWC_Rdptclr      (rdclr),
        .LWC_Wrptclr      (wrclr),
        .LWC_Fifo0_in     (f0_in),
        .LWC_Fifo1_in     (f1_in),
        .LWC_Window       (window),
        .LWC_Window_valid (win_valid),
        .LWC_Frame_done   (fdone)
`ifdef LWC_FRAME_CNT_EN
        ,
        .LWC_Frame_count  (fcnt)
`endif
    );

    // Line FIFO models: registered read port, shared pointer controls.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    int rp = 0, wp0 = 0, wp1 = 0;

    always @(posedge clk) begin
        f0_out <= ren0 ? mem0[rp] : '0;
        f1_out <= ren1 ? mem1[rp] : '0;
        if (!rdclr)     rp <= 0;
        else if (rdinc) rp <= (rp + 1) % DEPTH;
        if (!wrclr) begin
            wp0 <= 0;
            wp1 <= 0;
        end else begin
            if (wen0) begin mem0[wp0] <= f0_in; wp0 <= (wp0 + 1) % DEPTH; end
            if (wen1) begin mem1[wp1] <= f1_in; wp1 <= (wp1 + 1) % DEPTH; end
        end
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: image held as a plain 2-D array; windows are cut out of it.
    typedef struct {
        logic [9*DW-1:0] win;
        int              due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] img [H][W];
    int            m_row, m_col, gap, frames, win_seen;
    bit            gap_last_row, fd_expect, frame_complete;
    logic [9*DW-1:0] first_win, last_win;

    // Monitor: pops one expected window per observed Window_valid.
    always @(negedge clk) begin
        if (win_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got %h, expected none (t=%0t)", window, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("window_data", window, e.win);
                chk("window_latency", edge_cnt, e.due);
            end
            if (win_seen == 0) first_win = window;
            last_win = window;
            win_seen++;
        end
    end

    task automatic step(input bit want_v);
        bit   acc;
        exp_t e;
        @(negedge clk);
        chk("pixel_ready", ready, gap == 0);
        chk("rdptclr", rdclr, gap != 3);
        chk("wrptclr", wrclr, gap != 3);
        chk("frame_done", fdone, fd_expect);
        if (fd_expect) begin
            frames++;
`ifdef LWC_FRAME_CNT_EN
            chk("frame_count", fcnt, frames);
`endif
            frame_complete = 1'b1;
            fd_expect      = 1'b0;
            pv             = 1'b0;
            return;
        end
        if (gap == 3 && gap_last_row) fd_expect = 1'b1;
        acc = want_v && (gap == 0);
        if (gap > 0) gap = (gap == 3) ? 0 : gap + 1;
        pv = want_v;
        pd = want_v ? img[m_row][m_col] : DW'($urandom);
        if (acc) begin
            if (m_row >= 2 && m_col >= 2) begin
                for (int k = 0; k < 9; k++)
                    e.win[k*DW +: DW] = img[m_row - 2 + k/3][m_col - 2 + k%3];
                e.due = edge_cnt + 3;
                sb.push_back(e);
            end
            if (m_col == W - 1) begin
                gap          = 1;
                gap_last_row = (m_row == H - 1);
                m_col        = 0;
                m_row        = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pv  = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_wen", {wen0, wen1}, 0);
        chk("rst_ren", {ren0, ren1}, 0);
        chk("rst_rdinc", rdinc, 0);
        chk("rst_clears", {rdclr, wrclr}, 0);
        chk("rst_window", window, 0);
        chk("rst_window_valid", win_valid, 0);
        chk("rst_frame_done", fdone, 0);
`ifdef LWC_FRAME_CNT_EN
        chk("rst_frame_count", fcnt, 0);
`endif
        sb.delete();
        m_row = 0; m_col = 0; gap = 0; frames = 0;
        gap_last_row = 1'b0; fd_expect = 1'b0;
        rst = 1'b0;
    endtask

    // mode 0: valid always high, 1: toggled 1010, 2: random valid and data
    task automatic run_frame(input int mode);
        logic [9*DW-1:0] exp_first, exp_last;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (mode == 2) ? DW'($urandom) : DW'(r * 16 + c);
        win_seen       = 0;
        frame_complete = 1'b0;
        for (int i = 0; i < 2000 && !frame_complete; i++) begin
            case (mode)
                0:       step(1'b1);
                1:       step(i % 2 == 0);
                default: step($urandom_range(0, 3) != 0);
            endcase
        end
        if (!frame_complete) chk("frame_timeout", 0, 1);
        chk("window_count", win_seen, 6);
        chk("scoreboard_empty", sb.size(), 0);
        if (mode != 2) begin
            exp_first = {16'h22, 16'h21, 16'h20, 16'h12, 16'h11, 16'h10, 16'h02, 16'h01, 16'h00};
            exp_last  = {16'h34, 16'h33, 16'h32, 16'h24, 16'h23, 16'h22, 16'h14, 16'h13, 16'h12};
            chk("first_window", first_win, exp_first);
            chk("last_window", last_win, exp_last);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();
        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(2);
        // Abort a frame in row 2, column 3, then require a clean fresh frame.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = DW'(r * 16 + c);
        for (int i = 0; i < 200 && !(m_row == 2 && m_col == 3); i++) step(1'b1);
        do_reset();
        run_frame(0);
        repeat (4) step(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
